// File: rtl/int8008_pkg.sv
// Shared definitions for the 8008 interrupt arbiter: CPU state codes ({S0,S1,S2} order),
// arbiter FSM states and RST opcode construction.
package int8008_pkg;

    localparam logic [2:0] S_WAIT    = 3'b000;
    localparam logic [2:0] S_T2      = 3'b001;
    localparam logic [2:0] S_T1      = 3'b010;
    localparam logic [2:0] S_T1I     = 3'b011;
    localparam logic [2:0] S_T3      = 3'b100;
    localparam logic [2:0] S_T5      = 3'b101;
    localparam logic [2:0] S_STOPPED = 3'b110;
    localparam logic [2:0] S_T4      = 3'b111;

    localparam logic [2:0] RST_LOW = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_ACKCYC
    } fsm_e;

    function automatic logic [7:0] rst_opcode(input logic [2:0] vec);
        return {2'b00, vec, RST_LOW};
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Combinational priority encoder over the enabled pending requests.
// INT_RR_PRIORITY_EN: search starts at start_idx and wraps; otherwise index 0 always wins.
module int_prio_enc #(
    parameter int NSRC = 4,
    parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req_vec,
    input  logic [IW-1:0]   start_idx,
    output logic            vld,
    output logic [IW-1:0]   idx
);

`ifdef INT_RR_PRIORITY_EN
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int off = NSRC - 1; off >= 0; off--) begin
            if (req_vec[(int'(start_idx) + off) % NSRC]) begin
                vld = 1'b1;
                idx = IW'((int'(start_idx) + off) % NSRC);
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start_idx;

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/int_arbiter_8008.sv
// 8008 interrupt arbiter: edge-latched requests, startup kick, INTERRUPT/ack-cycle sequencing on clk2 falls.
// Optional round-robin source priority via INT_RR_PRIORITY_EN.
module int_arbiter_8008
    import int8008_pkg::*;
#(
    parameter int              NSRC        = 4,
    parameter logic [3*NSRC-1:0] VEC_MAP   = {3'd3, 3'd2, 3'd1, 3'd0},
    parameter logic [2:0]      STARTUP_VEC = 3'd0
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            clk2,
    input  logic            sync,
    input  logic [2:0]      state,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    output logic            interrupt,
    output logic            int_ack_cycle,
    output logic [7:0]      int_code,
    output logic [NSRC-1:0] ack,
    output logic [NSRC-1:0] pending,
    output logic            busy
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    fsm_e            fsm_q;
    logic            clk2_q;
    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] pending_q;
    logic [NSRC-1:0] ack_q;
    logic [NSRC-1:0] ack_d;
    logic            startup_pend_q;
    logic            startup_grant_q;
    logic            interrupt_q;
    logic            iac_q;
    logic [7:0]      code_q;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   start_idx;
    logic            enc_vld;
    logic [IW-1:0]   enc_idx;
    logic [2:0]      vec_sel;
    logic            tick;
    logic [NSRC-1:0] rise;

    assign tick = clk2_q & ~clk2;
    assign rise = req & ~req_q;

`ifdef INT_RR_PRIORITY_EN
    logic [IW-1:0] last_q;
    assign start_idx = (int'(last_q) == NSRC - 1) ? '0 : last_q + IW'(1);
`else
    assign start_idx = '0;
`endif

    int_prio_enc #(.NSRC(NSRC), .IW(IW)) u_enc (
        .req_vec   (pending_q & mask),
        .start_idx (start_idx),
        .vld       (enc_vld),
        .idx       (enc_idx)
    );

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (enc_idx == IW'(i)) vec_sel = VEC_MAP[3*i +: 3];
        end
    end

    // Ack is computed one step early so pending can clear on the same edge the pulse appears.
    always_comb begin
        ack_d = '0;
        if (fsm_q == ST_ASSERT && tick && state == S_T1I && !startup_grant_q) begin
            for (int i = 0; i < NSRC; i++) ack_d[i] = (grant_q == IW'(i));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            fsm_q           <= ST_IDLE;
            clk2_q          <= 1'b0;
            req_q           <= req;   // a request held across reset is not a new edge
            pending_q       <= '0;
            ack_q           <= '0;
            startup_pend_q  <= 1'b1;
            startup_grant_q <= 1'b0;
            interrupt_q     <= 1'b0;
            iac_q           <= 1'b0;
            code_q          <= rst_opcode(3'd0);
            grant_q         <= '0;
`ifdef INT_RR_PRIORITY_EN
            last_q          <= IW'(NSRC - 1);
`endif
        end else begin
            clk2_q    <= clk2;
            req_q     <= req;
            pending_q <= (pending_q & ~ack_d) | rise;
            ack_q     <= ack_d;
            case (fsm_q)
                ST_IDLE: begin
                    if (tick && !sync) begin
                        if (startup_pend_q && state == S_STOPPED) begin
                            startup_pend_q  <= 1'b0;
                            startup_grant_q <= 1'b1;
                            code_q          <= rst_opcode(STARTUP_VEC);
                            interrupt_q     <= 1'b1;
                            fsm_q           <= ST_ASSERT;
                        end else if (!startup_pend_q && enc_vld) begin
                            startup_grant_q <= 1'b0;
                            grant_q         <= enc_idx;
                            code_q          <= rst_opcode(vec_sel);
                            interrupt_q     <= 1'b1;
                            fsm_q           <= ST_ASSERT;
`ifdef INT_RR_PRIORITY_EN
                            last_q          <= enc_idx;
`endif
                        end
                    end
                end
                ST_ASSERT: begin
                    if (tick && state == S_T1I) begin
                        interrupt_q <= 1'b0;
                        iac_q       <= 1'b1;
                        fsm_q       <= ST_ACKCYC;
                    end
                end
                ST_ACKCYC: begin
                    if (tick && state == S_T3 && !sync) begin
                        iac_q <= 1'b0;
                        fsm_q <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign interrupt     = interrupt_q;
    assign int_ack_cycle = iac_q;
    assign int_code      = code_q;
    assign ack           = ack_q;
    assign pending       = pending_q;
    assign busy          = (fsm_q != ST_IDLE);

endmodule
